mmio_irq_ctrl: RTL and testbench

Parametrised memory-mapped interrupt and event-capture controller for the game processor's virtual memory space. Collects `NUM_IRQ` interrupt sources (keyboard, VGA frame, pipe refresh, and spares) into sticky pending bits with a per-channel enable mask, write-1-to-clear semantics and a priority-encoded active ID. Buffers keyboard scan bytes in a FIFO so no keystroke is lost between polls. Sits on the processor data-memory port beside the game-state registers and decodes a window starting at `BASE_ADDR`.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/mmio_irq_ctrl.sv | 134 +++++++++++++
 tb/tb_mmio_irq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared register map and field positions for the mmio_irq_ctrl register window.
package mmio_pkg;

    localparam logic [2:0] OFS_PENDING     = 3'd0;
    localparam logic [2:0] OFS_ENABLE      = 3'd1;
    localparam logic [2:0] OFS_ACTIVE_ID   = 3'd2;
    localparam logic [2:0] OFS_FIFO_DATA   = 3'd3;
    localparam logic [2:0] OFS_FIFO_STATUS = 3'd4;
    localparam int         NUM_REGS        = 5;

    localparam int ST_COUNT_W    = 16;
    localparam int ST_OVF_BIT    = 16;
    localparam int ST_FULL_BIT   = 17;
    localparam int ST_EMPTY_BIT  = 18;

    localparam int AID_VALID_BIT = 31;
    localparam int AID_W         = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push, w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_irq_ctrl.sv
// Memory-mapped interrupt controller with keyboard capture FIFO.
// IRQ_EDGE_DETECT_EN: treat irq_in as levels and set pending on rising edges only.
module mmio_irq_ctrl
    import mmio_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int NUM_IRQ    = 4,
    parameter int BASE_ADDR  = 6000,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wren,
    input  logic               rden,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  data,
    output logic [DATA_W-1:0]  q_data,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               fifo_push,
    input  logic [FIFO_W-1:0]  fifo_din,
    output logic               irq_out
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]  r_q_data;
    logic               r_irq_out;
    logic [NUM_IRQ-1:0] r_pend, r_en;
    logic               r_ovf;

    logic [ADDR_W-1:0]  w_ofs;
    logic [2:0]         w_sel;
    logic               w_hit, w_wr, w_rd;
    logic [NUM_IRQ-1:0] w_set, w_clr, w_act;
    logic [AID_W-1:0]   w_aid;
    logic               w_pop, w_full, w_empty, w_ovf_set, w_ovf_clr;
    logic [FIFO_W-1:0]  w_fifo_dout;
    logic [CNT_W-1:0]   w_count;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_unused;

    assign w_ofs    = address - ADDR_W'(BASE_ADDR);
    assign w_hit    = (address >= ADDR_W'(BASE_ADDR)) && (w_ofs < ADDR_W'(NUM_REGS));
    assign w_sel    = w_ofs[2:0];
    assign w_wr     = wren && w_hit;
    assign w_rd     = rden && !wren;
    assign w_unused = ^data;

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] r_irq_d;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_irq_d <= '0;
        else       r_irq_d <= irq_in;
    end
    assign w_set = irq_in & ~r_irq_d;
`else
    assign w_set = irq_in;
`endif

    assign w_clr = (w_wr && w_sel == OFS_PENDING) ? data[NUM_IRQ-1:0] : '0;
    assign w_act = r_pend & r_en;

    // Lowest-index active channel wins, so scan from the top down.
    always_comb begin
        w_aid = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (w_act[i]) w_aid = AID_W'(i);
    end

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_W)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (fifo_push),
        .i_pop   (w_pop),
        .i_din   (fifo_din),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_pop     = w_rd && w_hit && (w_sel == OFS_FIFO_DATA) && !w_empty;
    assign w_ovf_set = fifo_push && w_full && !w_pop;
    assign w_ovf_clr = w_wr && (w_sel == OFS_FIFO_STATUS) && data[ST_OVF_BIT];

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_sel)
                OFS_PENDING: w_rdata[NUM_IRQ-1:0] = r_pend;
                OFS_ENABLE:  w_rdata[NUM_IRQ-1:0] = r_en;
                OFS_ACTIVE_ID: begin
                    if (|w_act) begin
                        w_rdata[AID_VALID_BIT] = 1'b1;
                        w_rdata[AID_W-1:0]     = w_aid;
                    end
                end
                OFS_FIFO_DATA: begin
                    if (w_empty) w_rdata[AID_VALID_BIT]  = 1'b1;
                    else         w_rdata[FIFO_W-1:0]     = w_fifo_dout;
                end
                OFS_FIFO_STATUS: begin
                    w_rdata[ST_COUNT_W-1:0] = ST_COUNT_W'(w_count);
                    w_rdata[ST_OVF_BIT]     = r_ovf;
                    w_rdata[ST_FULL_BIT]    = w_full;
                    w_rdata[ST_EMPTY_BIT]   = w_empty;
                end
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q_data  <= '0;
            r_irq_out <= 1'b0;
            r_pend    <= '0;
            r_en      <= '1;
            r_ovf     <= 1'b0;
        end else begin
            if (w_rd) r_q_data <= w_rdata;
            r_irq_out <= |w_act;
            // Set wins over a same-cycle W1C.
            r_pend    <= (r_pend & ~w_clr) | w_set;
            if (w_wr && w_sel == OFS_ENABLE) r_en <= data[NUM_IRQ-1:0];
            r_ovf     <= w_ovf_set | (r_ovf & ~w_ovf_clr);
        end
    end

    assign q_data  = r_q_data;
    assign irq_out = r_irq_out;

endmodule

// File: tb/tb_mmio_irq_ctrl.sv
// Directed, table-driven bench for mmio_irq_ctrl; each row is one bus cycle plus optional output checks.
module tb_mmio_irq_ctrl;
    localparam int B = 6000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wren = 1'b0, rden = 1'b0;
    logic [16:0] address = '0;
    logic [31:0] data = '0;
    logic [31:0] q_data;
    logic [3:0]  irq_in = '0;
    logic        fifo_push = 1'b0;
    logic [7:0]  fifo_din = '0;
    logic        irq_out;

    int n_cmp = 0;
    int n_mis = 0;

    mmio_irq_ctrl dut (
        .clock(clock), .reset(reset), .wren(wren), .rden(rden),
        .address(address), .data(data), .q_data(q_data),
        .irq_in(irq_in), .fifo_push(fifo_push), .fifo_din(fifo_din),
        .irq_out(irq_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr, rd;
        logic [16:0] addr;
        logic [31:0] d;
        logic [3:0]  irq;
        logic        push;
        logic [7:0]  din;
        logic        cq;
        logic [31:0] eq;
        logic        ci, ei;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic wr, logic rd, int o, logic [31:0] d, logic [3:0] irq,
                                logic push, logic [7:0] din, logic cq, logic [31:0] eq,
                                logic ci, logic ei);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = 17'(B + o); v.d = d; v.irq = irq;
        v.push = push; v.din = din; v.cq = cq; v.eq = eq; v.ci = ci; v.ei = ei;
        return v;
    endfunction

    function automatic vec_t R(int o, logic [31:0] e);
        return mk(0, 1, o, 0, 0, 0, 0, 1, e, 0, 0);
    endfunction
    function automatic vec_t RI(int o, logic [31:0] e, logic ei);
        return mk(0, 1, o, 0, 0, 0, 0, 1, e, 1, ei);
    endfunction
    function automatic vec_t W(int o, logic [31:0] d);
        return mk(1, 0, o, d, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t WI(int o, logic [31:0] d, logic ei);
        return mk(1, 0, o, d, 0, 0, 0, 0, 0, 1, ei);
    endfunction
    function automatic vec_t P(logic [3:0] irq, logic ci, logic ei);
        return mk(0, 0, 0, 0, irq, 0, 0, 0, 0, ci, ei);
    endfunction
    function automatic vec_t PU(logic [7:0] din);
        return mk(0, 0, 0, 0, 0, 1, din, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called at a negedge: drive for one cycle, then check at the following negedge.
    task automatic run_vec(input vec_t v, input string nm);
        wren = v.wr; rden = v.rd; address = v.addr; data = v.d;
        irq_in = v.irq; fifo_push = v.push; fifo_din = v.din;
        @(negedge clock);
        wren = 1'b0; rden = 1'b0; irq_in = '0; fifo_push = 1'b0;
        if (v.cq) chk({nm, " q_data"}, q_data, v.eq);
        if (v.ci) chk({nm, " irq_out"}, {31'b0, irq_out}, {31'b0, v.ei});
    endtask

    initial begin
        // Reset state and register map
        vq.push_back(R(1, 32'hF));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hF, 0, 0));
        vq.push_back(R(5, 32'h0));
        vq.push_back(R(4, 32'h0004_0000));
        vq.push_back(R(-1, 32'h0));
        vq.push_back(R(3, 32'h8000_0000));
        vq.push_back(R(0, 32'h0));
        vq.push_back(R(2, 32'h0));
        // Single pulse, ACTIVE_ID, W1C
        vq.push_back(P(4'h4, 1, 0));
        vq.push_back(P(4'h0, 1, 1));
        vq.push_back(RI(0, 32'h4, 1));
        vq.push_back(R(2, 32'h8000_0002));
        vq.push_back(WI(0, 32'h4, 1));
        vq.push_back(P(4'h0, 1, 0));
        vq.push_back(R(0, 32'h0));
        // Masking
        vq.push_back(P(4'hA, 1, 0));
        vq.push_back(WI(1, 32'h8, 1));
        vq.push_back(RI(2, 32'h8000_0003, 1));
        vq.push_back(WI(1, 32'h0, 1));
        vq.push_back(RI(0, 32'hA, 0));
        vq.push_back(RI(2, 32'h0, 0));
        vq.push_back(W(1, 32'hF));
        vq.push_back(WI(0, 32'hA, 1));
        vq.push_back(P(4'h0, 1, 0));
        // Set beats same-cycle W1C
        vq.push_back(P(4'h1, 0, 0));
        vq.push_back(P(4'h0, 0, 0));
        vq.push_back(mk(1, 0, 0, 32'h1, 4'h1, 0, 0, 0, 0, 0, 0));
        vq.push_back(R(0, 32'h1));
        vq.push_back(W(0, 32'h1));
        vq.push_back(R(0, 32'h0));
        // FIFO overflow
        for (int i = 0; i < 9; i++) vq.push_back(PU(8'(8'h10 + i)));
        vq.push_back(R(4, 32'h0003_0008));
        for (int i = 0; i < 8; i++) vq.push_back(R(3, 32'(8'h10 + i)));
        vq.push_back(R(3, 32'h8000_0000));
        vq.push_back(R(4, 32'h0005_0000));
        vq.push_back(W(4, 32'h0001_0000));
        vq.push_back(R(4, 32'h0004_0000));
        // Push+pop while full, pointer wrap
        for (int i = 0; i < 8; i++) vq.push_back(PU(8'(8'h20 + i)));
        vq.push_back(R(4, 32'h0002_0008));
        vq.push_back(mk(0, 1, 3, 0, 0, 1, 8'h28, 1, 32'h20, 0, 0));
        vq.push_back(R(4, 32'h0002_0008));
        for (int i = 1; i < 9; i++) vq.push_back(R(3, 32'(8'h20 + i)));
        vq.push_back(R(4, 32'h0004_0000));
        // Push+pop while empty; write to FIFO_DATA ignored
        vq.push_back(mk(0, 1, 3, 0, 0, 1, 8'h33, 1, 32'h8000_0000, 0, 0));
        vq.push_back(R(4, 32'h0000_0001));
        vq.push_back(R(3, 32'h33));
        vq.push_back(W(3, 32'h55));
        vq.push_back(R(4, 32'h0004_0000));

        repeat (2) @(negedge clock);
        chk("reset q_data", q_data, 32'h0);
        chk("reset irq_out", {31'b0, irq_out}, 32'h0);
        reset = 1'b0;

        foreach (vq[i]) run_vec(vq[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-operation
        run_vec(PU(8'h77), "ar push");
        run_vec(P(4'h4, 0, 0), "ar irq");
        run_vec(P(4'h0, 1, 1), "ar irq_hi");
        run_vec(R(1, 32'hF), "ar en");
        #2 reset = 1'b1;
        #1;
        chk("async rst q_data", q_data, 32'h0);
        chk("async rst irq_out", {31'b0, irq_out}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        run_vec(R(4, 32'h0004_0000), "ar status");
        run_vec(R(0, 32'h0), "ar pend");

`ifdef IRQ_EDGE_DETECT_EN
        irq_in = 4'h2;
        repeat (5) @(negedge clock);
        irq_in = 4'h0;
        run_vec(R(0, 32'h2), "ed level");
        run_vec(W(0, 32'h2), "ed clr");
        run_vec(R(0, 32'h0), "ed cleared");
        irq_in = 4'h2;
        @(negedge clock);
        wren = 1'b1; address = 17'(B); data = 32'h2;
        @(negedge clock);
        wren = 1'b0;
        repeat (3) @(negedge clock);
        rden = 1'b1; address = 17'(B);
        @(negedge clock);
        rden = 1'b0;
        chk("ed w1c while high", q_data, 32'h0);
        irq_in = 4'h0;
        @(negedge clock);
        irq_in = 4'h2;
        @(negedge clock);
        irq_in = 4'h0;
        run_vec(R(0, 32'h2), "ed re-edge");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
